// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: program memory read port plus the instruction issue handshake
// towards the core.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        instr;
  logic [7:0]        instr_dest;
  logic [7:0]        instr_src;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  modport master (
    output mem_rd_en, mem_addr, instr, instr_dest, instr_src, instr_valid, pc, halted,
    input  mem_rdata, instr_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, instr, instr_dest, instr_src, instr_valid, pc, halted,
    output mem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencer: reads opcode and operand bytes from program memory,
// issues them to the core over valid/ready, and follows JUMP/HALT/end-of-memory.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [7:0]  OP_HALT   = 8'h13,
  parameter logic [7:0]  OP_JUMP   = 8'h15
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  // One extra bit so next-PC overflow past the memory end is seen, not wrapped
  localparam int unsigned PW    = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(MEM_DEPTH);

  typedef enum logic [2:0] {
    RD_OP = 3'd0,
    LD_OP = 3'd1,
    LD_B1 = 3'd2,
    LD_B2 = 3'd3,
    ISSUE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        op_q, op_d;
  logic [7:0]        dest_q, dest_d;
  logic [7:0]        src_q, src_d;
  logic [1:0]        n_q, n_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;

  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [1:0]        n_rdata_c;
  logic [PW-1:0]     pc1_c, pc2_c, next_pc_c;

  function automatic logic [1:0] op_count(input logic [7:0] op);
    if (op <= 8'h0C) return 2'd2;
    if ((op >= 8'h0D && op <= 8'h12) || op == 8'h14 || op == OP_JUMP || op == OP_HALT)
      return 2'd1;
    return 2'd0;
  endfunction

  assign n_rdata_c = op_count(bus.mem_rdata);
  assign pc1_c     = PW'(pc_q) + PW'(1);
  assign pc2_c     = PW'(pc_q) + PW'(2);
  assign next_pc_c = (op_q == OP_JUMP) ? PW'(src_q) : (PW'(pc_q) + PW'(1) + PW'(n_q));

  // Next-state and datapath updates
  always_comb begin
    state_d   = state;
    pc_d      = pc_q;
    op_d      = op_q;
    dest_d    = dest_q;
    src_d     = src_q;
    n_d       = n_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    rd_en_c   = 1'b0;
    rd_addr_c = pc_q;

    case (state)
      RD_OP: begin
        rd_en_c = 1'b1;
        state_d = LD_OP;
      end
      LD_OP: begin
        op_d = bus.mem_rdata;
        n_d  = n_rdata_c;
        if (n_rdata_c == 2'd0) begin
          dest_d  = 8'h00;
          src_d   = 8'h00;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else if (pc1_c >= DEPTH) begin
          halted_d = 1'b1;
          state_d  = DONE;
        end else begin
          rd_en_c   = 1'b1;
          rd_addr_c = pc1_c[ADDR_W-1:0];
          state_d   = LD_B1;
        end
      end
      LD_B1: begin
        if (op_q == OP_JUMP) begin
          dest_d  = 8'h00;
          src_d   = bus.mem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end else begin
          dest_d = bus.mem_rdata;
          if (n_q == 2'd1) begin
            src_d   = 8'h00;
            valid_d = 1'b1;
            state_d = ISSUE;
          end else if (pc2_c >= DEPTH) begin
            halted_d = 1'b1;
            state_d  = DONE;
          end else begin
            rd_en_c   = 1'b1;
            rd_addr_c = pc2_c[ADDR_W-1:0];
            state_d   = LD_B2;
          end
        end
      end
      LD_B2: begin
        src_d   = bus.mem_rdata;
        valid_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.instr_ready) begin
          valid_d = 1'b0;
          if (op_q == OP_HALT || next_pc_c >= DEPTH) begin
            halted_d = 1'b1;
            state_d  = DONE;
          end else begin
            pc_d    = next_pc_c[ADDR_W-1:0];
            state_d = RD_OP;
          end
        end
      end
      DONE: begin
        halted_d = 1'b1;
      end
      default: begin
        halted_d = 1'b1;
        state_d  = DONE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RD_OP;
      pc_q     <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      n_q      <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      n_q      <= n_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Read strobe decoded from state so RD_OP reads in its own cycle; held low in reset
  assign bus.mem_rd_en   = rd_en_c & ~reset;
  assign bus.mem_addr    = rd_addr_c;
  assign bus.instr       = op_q;
  assign bus.instr_dest  = dest_q;
  assign bus.instr_src   = src_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;

endmodule
